// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared state encoding and constants for the UART transmit scheduler
package uart_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, BUSY = 2'd2, HOLD = 2'd3} state_t;
  localparam int ACK_TIMEOUT_DEF = 1023;
  localparam logic [7:0] TX_DATA_RST = 8'hFF;
endpackage

// File: rtl/uart_tx_sched_rr_pick.sv
// rr_pick: rotate-priority picker, first set req at or after ptr (cyclic)
//   req : request vector
//   ptr : highest-priority index
//   gnt : one-hot winner, 0 when no request
//   any : at least one request present
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 any
);
  logic [$clog2(N)-1:0] idx;
  // Walk from the lowest-priority offset down so the closest request to ptr wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ($clog2(N))'((int'(ptr) + k) % N);
      if (req[idx]) begin
        gnt = '0;
        gnt[idx] = 1'b1;
      end
    end
  end
  assign any = |req;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: packet-level round-robin scheduler sharing one UART transmitter
//   clk, rst      : clock, synchronous active-high reset
//   req_valid/req_data/req_last : per-requester byte offer (byte i at [8i+7:8i])
//   req_ready     : byte i consumed this cycle
//   grant         : one-hot packet owner, 0 when free
//   tx_dataready, tx_data : start request and held byte to the transmitter
//   tx_rts        : transmitter status, low while a frame is accepted/in progress
//   err_timeout   : one-cycle pulse when a start request is abandoned
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   tx_dataready,
  output logic [7:0]             tx_data,
  input  logic                   tx_rts,
  output logic                   err_timeout
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  state_t state, state_n;
  logic [PW-1:0] ptr, owner, win, sel, rel_ptr;
  logic [CW-1:0] cnt;
  logic last_q, pick_any, take, timeout, release_lock;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [7:0] bytes [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) assign bytes[i] = req_data[8*i +: 8];
  rr_pick #(.N(NUM_REQ)) u_pick (
    .req (req_valid),
    .ptr (ptr),
    .gnt (pick_gnt),
    .any (pick_any)
  );
  always_comb begin
    win = '0;
    for (int i = 0; i < NUM_REQ; i++) if (pick_gnt[i]) win = PW'(i);
  end
  // While a packet is locked only the owner is looked at; otherwise the picker decides.
  assign sel = (state == HOLD) ? owner : win;
  assign take = (state == IDLE && tx_rts && pick_any) || (state == HOLD && req_valid[owner]);
  assign timeout = state == SEND && tx_rts && cnt == CW'(ACK_TIMEOUT);
  assign release_lock = timeout || (state == BUSY && tx_rts && last_q);
  assign rel_ptr = (owner == PW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign req_ready = take ? (NUM_REQ'(1) << sel) : '0;
  assign grant = (state == IDLE) ? '0 : (NUM_REQ'(1) << owner);
  assign tx_dataready = state == SEND;
  assign err_timeout = timeout;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = take ? SEND : IDLE;
      SEND: state_n = !tx_rts ? BUSY : (timeout ? IDLE : SEND);
      BUSY: state_n = tx_rts ? (last_q ? IDLE : HOLD) : BUSY;
      HOLD: state_n = take ? SEND : HOLD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      last_q  <= 1'b0;
      tx_data <= TX_DATA_RST;
    end else begin
      state <= state_n;
      if (take) begin
        tx_data <= bytes[sel];
        last_q  <= req_last[sel];
        owner   <= sel;
      end
      if (release_lock) ptr <= rel_ptr;
      cnt <= (state == SEND) ? cnt + CW'(cnt != CW'(ACK_TIMEOUT)) : '0;
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed table plus corner sequences against a small transmitter model
module tb_uart_tx_sched;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid, req_last, req_ready, grant;
  logic [31:0] req_data;
  logic tx_dataready, tx_rts, err_timeout;
  logic [7:0] tx_data;

  uart_tx_sched #(.NUM_REQ(4), .ACK_TIMEOUT(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .grant        (grant),
    .tx_dataready (tx_dataready),
    .tx_data      (tx_data),
    .tx_rts       (tx_rts),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int stab_err = 0, multi = 0, blk = 0, dr_run = 0, dr_len = 0;
  int tm_state = 0, tm_cnt = 0;
  logic force_high = 1'b0, stab_en = 1'b1;
  logic [3:0] block_mask = 4'h0;
  logic [7:0] cap;
  logic [7:0] sent [$];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  exp_ready;
    logic [7:0]  exp_byte;
  } vec_t;
  vec_t tv [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_n();
    @(negedge clk);
    #1;
  endtask

  task automatic pop_chk(input string nm, input logic [7:0] exp);
    int n;
    logic [31:0] got;
    n = 0;
    while (sent.size() == 0 && n < 3000) begin tick_n(); n++; end
    got = (sent.size() > 0) ? {24'h0, sent.pop_front()} : 32'hDEADBEEF;
    chk(nm, got, {24'h0, exp});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick_n();
    while (!(grant == 4'h0 && tm_state == 0 && tx_rts && !tx_dataready) && n < 3000) begin
      tick_n();
      n++;
    end
    chk("idle_grant0", {31'h0, grant == 4'h0 && tm_state == 0}, 32'h1);
  endtask

  task automatic offer(input int idx, input logic [7:0] b, input logic l);
    int n;
    n = 0;
    req_data[8*idx +: 8] = b;
    req_last[idx] = l;
    req_valid[idx] = 1'b1;
    #1;
    while (!req_ready[idx] && n < 3000) begin tick_n(); n++; end
    chk($sformatf("offer_ready%0d", idx), {31'h0, req_ready[idx]}, 32'h1);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  // Transmitter: sees dataready, drops rts one cycle later, 10-cycle frame, 2-cycle stop bit.
  initial begin
    tx_rts = 1'b1;
    forever begin
      @(negedge clk);
      if (force_high) begin
        tx_rts = 1'b1;
        tm_state = 0;
      end else begin
        case (tm_state)
          0: if (tx_dataready) tm_state = 1;
          1: begin tx_rts = 1'b0; cap = tx_data; tm_cnt = 0; tm_state = 2; end
          2: begin
            if (stab_en && tx_data !== cap) stab_err++;
            tm_cnt++;
            if (tm_cnt == 10) begin tx_rts = 1'b1; sent.push_back(cap); tm_cnt = 0; tm_state = 3; end
          end
          default: begin tm_cnt++; if (tm_cnt == 2) tm_state = 0; end
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (tx_dataready) dr_run++;
      else if (dr_run > 0) begin dr_len = dr_run; dr_run = 0; end
      if ($countones(req_ready) > 1) multi++;
      if ((req_ready & block_mask) != 4'h0) blk++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    logic prev_rts;
    int viol;
    int pk_left [4];
    int rem [4];
    int gap [4];
    logic [3:0] rdy;
    logic [7:0] expq [$];
    int cyc;
    tv[0]  = '{4'b1010, 32'hA3A2A1A0, 4'b0010, 8'hA1};
    tv[1]  = '{4'b1000, 32'hA3A2A1A0, 4'b1000, 8'hA3};
    tv[2]  = '{4'b0001, 32'hA3A2A155, 4'b0001, 8'h55};
    tv[3]  = '{4'b1111, 32'hA3A2A1A0, 4'b0010, 8'hA1};
    tv[4]  = '{4'b1111, 32'hA3A2A1A0, 4'b0100, 8'hA2};
    tv[5]  = '{4'b1111, 32'hA3A2A1A0, 4'b1000, 8'hA3};
    tv[6]  = '{4'b1111, 32'hA3A2A1A0, 4'b0001, 8'hA0};
    tv[7]  = '{4'b0001, 32'hA3A2A1A0, 4'b0001, 8'hA0};
    tv[8]  = '{4'b0100, 32'hA3A2A1A0, 4'b0100, 8'hA2};
    tv[9]  = '{4'b0011, 32'hA3A2A1A0, 4'b0001, 8'hA0};
    tv[10] = '{4'b0010, 32'hA3A2A1A0, 4'b0010, 8'hA1};
    tv[11] = '{4'b1000, 32'hA3A2A1A0, 4'b1000, 8'hA3};
    rst = 1'b1;
    req_valid = 4'h0;
    req_last = 4'h0;
    req_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_dataready", tx_dataready, 0);
    chk("rst_tx_data", tx_data, 32'hFF);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      wait_idle();
      req_data = tv[i].data;
      req_last = 4'hF;
      req_valid = tv[i].valid;
      #1;
      n = 0;
      while (req_ready == 4'h0 && n < 500) begin tick_n(); n++; end
      chk($sformatf("v%0d_ready", i), req_ready, tv[i].exp_ready);
      @(posedge clk);
      #1;
      req_valid = 4'h0;
      chk($sformatf("v%0d_grant", i), grant, tv[i].exp_ready);
      chk($sformatf("v%0d_dataready", i), tx_dataready, 1);
      chk($sformatf("v%0d_tx_data", i), tx_data, tv[i].exp_byte);
      pop_chk($sformatf("v%0d_line", i), tv[i].exp_byte);
      chk($sformatf("v%0d_dr_len", i), dr_len, 2);
    end

    // Packet lock: req0 three bytes with a long HOLD stall, req2 waiting throughout.
    wait_idle();
    req_data[23:16] = 8'hA2;
    req_last[2] = 1'b1;
    req_valid[2] = 1'b1;
    block_mask = 4'b0100;
    offer(0, 8'h01, 1'b0);
    repeat (70) tick_n();
    chk("hold_grant", grant, 4'b0001);
    chk("hold_dataready", tx_dataready, 0);
    offer(0, 8'h02, 1'b0);
    offer(0, 8'h03, 1'b1);
    block_mask = 4'h0;
    n = 0;
    #1;
    while (!req_ready[2] && n < 500) begin tick_n(); n++; end
    chk("lock_req2_ready", {31'h0, req_ready[2]}, 1);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    pop_chk("lock_b1", 8'h01);
    pop_chk("lock_b2", 8'h02);
    pop_chk("lock_b3", 8'h03);
    pop_chk("lock_req2", 8'hA2);
    chk("lock_blocked", blk, 0);

    // Timeout: transmitter never drops rts.
    wait_idle();
    force_high = 1'b1;
    offer(1, 8'h77, 1'b1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!err_timeout && n < 40);
    chk("timeout_cycles", n, 16);
    chk("timeout_grant_during", grant, 4'b0010);
    @(posedge clk);
    #1;
    chk("timeout_pulse_len", err_timeout, 0);
    chk("timeout_grant", grant, 0);
    chk("timeout_dataready", tx_dataready, 0);
    force_high = 1'b0;
    offer(2, 8'h5A, 1'b1);
    pop_chk("timeout_next", 8'h5A);

    // Reset in the middle of a frame.
    wait_idle();
    offer(0, 8'hC3, 1'b1);
    n = 0;
    while (tx_rts && n < 100) begin tick_n(); n++; end
    repeat (3) tick_n();
    stab_en = 1'b0;
    rst = 1'b1;
    req_data[15:8] = 8'h99;
    req_last[1] = 1'b1;
    req_valid[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_tx_data", tx_data, 32'hFF);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_dataready", tx_dataready, 0);
    chk("mid_rst_ready", req_ready, 0);
    rst = 1'b0;
    prev_rts = 1'b0;
    viol = 0;
    n = 0;
    tick_n();
    while (!tx_dataready && n < 200) begin
      if (!tx_rts && req_ready != 4'h0) viol++;
      prev_rts = tx_rts;
      tick_n();
      n++;
    end
    chk("rst_wait_rts", {31'h0, prev_rts & tx_dataready}, 1);
    chk("rst_no_ready_busy", viol, 0);
    req_valid[1] = 1'b0;
    pop_chk("rst_inflight", 8'hC3);
    pop_chk("rst_next", 8'h99);
    wait_idle();
    stab_en = 1'b1;

    // Random packets from all four requesters.
    req_valid = 4'h0;
    for (int i = 0; i < 4; i++) begin pk_left[i] = 50; rem[i] = 0; gap[i] = $urandom_range(0, 3); end
    cyc = 0;
    while ((pk_left[0] + pk_left[1] + pk_left[2] + pk_left[3]) > 0 && cyc < 40000) begin
      tick_n();
      rdy = req_ready;
      for (int i = 0; i < 4; i++) if (rdy[i]) expq.push_back(req_data[8*i +: 8]);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) begin
          rem[i]--;
          if (rem[i] > 0) begin
            req_data[8*i +: 8] = 8'($urandom);
            req_last[i] = (rem[i] == 1);
          end else begin
            req_valid[i] = 1'b0;
            pk_left[i]--;
            gap[i] = $urandom_range(0, 6);
          end
        end else if (!req_valid[i] && pk_left[i] > 0) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            rem[i] = $urandom_range(1, 3);
            req_data[8*i +: 8] = 8'($urandom);
            req_last[i] = (rem[i] == 1);
            req_valid[i] = 1'b1;
          end
        end
      end
    end
    chk("rand_packets_left", pk_left[0] + pk_left[1] + pk_left[2] + pk_left[3], 0);
    n = 0;
    while (sent.size() < expq.size() && n < 3000) begin tick_n(); n++; end
    repeat (30) tick_n();
    chk("rand_count", sent.size(), expq.size());
    for (int i = 0; i < expq.size() && i < sent.size(); i++)
      chk($sformatf("rand_byte%0d", i), sent[i], expq[i]);
    chk("stability", stab_err, 0);
    chk("onehot_ready", multi, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Packet-level scheduler that shares the single UART transmitter (115200 baud, `dataready`/`data` in, `rts` out) between `NUM_REQ` on-chip byte sources. It sits directly in front of the transmitter and does four things:
- arbitrates round-robin at packet boundaries;
- locks the owner until its last byte;
- holds each byte stable for the full frame;
- recovers from a transmitter that never accepts.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters (2–8).
- `ACK_TIMEOUT`, 1023: cycles allowed in SEND for `tx_rts` to fall before abort.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  NUM_REQ  byte offered by requester i.
- `req_data`  in  8*NUM_REQ  byte i at bits [8i+7:8i].
- `req_last`  in  NUM_REQ  offered byte is last of packet.
- `req_ready`  out  NUM_REQ  byte i consumed this cycle (valid&ready transfer).
- `grant`  out  NUM_REQ  one-hot current packet owner; 0 when free.
- `tx_dataready`  out  1  start request to transmitter.
- `tx_data`  out  8  byte to transmitter; stable for whole frame.
- `tx_rts`  in  1  transmitter status; low = frame accepted/in progress, high = idle or in stop bit.
- `err_timeout`  out  1  one-cycle pulse on SEND abort.

## Operation
States: IDLE, SEND, BUSY, HOLD.

- **IDLE**
  - `grant`=0.
  - If `tx_rts`=1 and any `req_valid`:
    - winner = first valid index at or after `ptr`, cyclically; `ptr` is the index after the last owner.
    - `req_ready[winner]`=1 combinationally.
    - Latch `req_data[winner]` into `tx_data` and `req_last[winner]` into `last_q`.
    - `owner`←winner; → SEND.
  - `tx_rts`=0 in IDLE (transmitter still busy, e.g. after reset) blocks arbitration.
- **SEND**
  - `tx_dataready`=1; timeout counter increments from 0.
  - `tx_rts`=0 sampled → BUSY.
  - Counter reaches `ACK_TIMEOUT` first:
    - `err_timeout` pulse, `tx_dataready`→0.
    - Lock released; `ptr`←owner+1.
    - → IDLE.
    - The byte is dropped, not re-offered.
- **BUSY**
  - `tx_dataready`=0; `tx_data` held.
  - `tx_rts`=1 sampled:
    - `last_q`=1 → release lock, `ptr`←owner+1 (wrap at `NUM_REQ`), → IDLE.
    - `last_q`=0 → HOLD.
- **HOLD**
  - `grant` stays on owner.
  - Other requesters are ignored.
  - `req_valid[owner]`=1 → `req_ready[owner]`=1, latch byte/last, → SEND.
  - Owner may stall indefinitely; there is no timeout in HOLD.
- `req_ready` is only ever high for one index, only in IDLE or HOLD.
- `tx_data` changes only on a latch cycle; never in SEND/BUSY.
- After `rst`, `ptr`=0.

## Timing
- Reset values:
  - `grant`=0, `req_ready`=0, `tx_dataready`=0.
  - `tx_data`=8'hFF, `err_timeout`=0.
  - state=IDLE, `ptr`=0, counter=0.
- Latency from `req_valid` to `tx_dataready`:
  - `req_valid` high in IDLE at cycle N → `tx_dataready`=1 at cycle N+1.
  - The transmitter drops `rts` at N+2 and the scheduler samples it at N+2 → BUSY at N+3.
  - Minimum `tx_dataready` pulse is 2 cycles.
- `tx_rts` rises at the start of the stop bit. The next byte may enter SEND during the stop bit; the transmitter accepts it on reaching Idle, and `tx_data` is stable throughout.
- Back-to-back bytes of one packet:
  - `req_valid` held in HOLD → latch in the same cycle as entry-test.
  - No idle bit time beyond the transmitter's own.
- Simultaneous requests: strict rotation. With all valid, the owner order is 0,1,2,3,0…
- Timeout: abort occurs on the cycle the counter equals `ACK_TIMEOUT`. The counter width is `$clog2(ACK_TIMEOUT+1)` and it saturates, never wraps.
- `rst` mid-frame:
  - All outputs return to reset values next cycle.
  - The in-flight transmitter frame completes on its own; IDLE waits for `tx_rts`=1.

## Structure
- Package `uart_sched_pkg` holds:
  - state encoding, IDLE=2'd0, SEND=2'd1, BUSY=2'd2, HOLD=2'd3;
  - default `ACK_TIMEOUT`;
  - the `tx_data` reset constant 8'hFF.
- Sub-module `rr_pick`: combinational rotate-priority picker (`req`, `ptr` → one-hot `gnt`, `any`). Everything else lives in one sequential top.

## Test plan
- Single 1-byte packet:
  - stimulus: req0 byte 8'h55, `last`=1;
  - response: `req_ready[0]` at N, `tx_dataready` 2 cycles, `tx_data`=8'h55 until `tx_rts` rises, `grant` back to 0.
- Contention:
  - stimulus: req1 and req3 both valid, 1-byte packets, `ptr`=0;
  - response: req1 served first, then req3, then `ptr`=0; serial line carries 8'hA1 then 8'hA3.
- Packet lock:
  - stimulus: req0 sends 3 bytes (8'h01,8'h02,8'h03, last on third) while req2 valid throughout;
  - response: all three bytes are sent before any req2 byte; req0 stalls 50 cycles in HOLD and req2 is still blocked.
- Timeout:
  - stimulus: `tx_rts` forced high with `ACK_TIMEOUT`=16;
  - response: `err_timeout` pulse exactly 16 cycles after SEND entry, `grant`=0, next requester served.
- Reset during BUSY:
  - stimulus: `rst` 1 cycle mid-frame;
  - response: outputs at reset values; no new `tx_dataready` until `tx_rts`=1.
- Stability check: `tx_data` never changes while `tx_rts`=0 across 200 random packets from 4 requesters; every offered byte appears on `tx` exactly once in order.
